// File: rtl/iceblips_bus_pkg.sv
// Shared types and widths for the iceblips bus initiator.
package iceblips_bus_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 4;
  localparam logic [ADDR_W-1:0] IDLE_ADDR_DEF = 4'hf;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CYCLE
  } state_e;

endpackage

// File: rtl/iceblips_bus_master_if.sv
// On-chip command/response port of the bus initiator.
interface iceblips_bus_master_if;
  import iceblips_bus_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_error;

  // Requester side issues commands; the bus initiator serves them.
  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_error
  );

endinterface

// File: rtl/iceblips_phi2_gen.sv
// Free-running phi2 divider with one-clk strobes marking the clk edge where phi2 rises or falls.
module iceblips_phi2_gen #(
  parameter int PHI2_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic phi2_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int DIV_W = (PHI2_DIV > 1) ? $clog2(PHI2_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic             phi2_q, phi2_d;
  logic             toggle;

  always_comb begin
    toggle = (div_q == DIV_W'(PHI2_DIV - 1));
    div_d  = toggle ? '0 : div_q + 1'b1;
    phi2_d = phi2_q ^ toggle;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= '0;
      phi2_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      phi2_q <= phi2_d;
    end
  end

  // Strobes are high during the clk cycle that ends in the phi2 transition.
  assign phi2_o = phi2_q;
  assign rise_o = toggle & ~phi2_q;
  assign fall_o = toggle &  phi2_q;

endmodule

// File: rtl/iceblips_bus_master.sv
// Bus initiator: runs single read/write phi2 cycles on command, honouring the responder's be hold.
module iceblips_bus_master
  import iceblips_bus_pkg::*;
#(
  parameter int                PHI2_DIV   = 2,
  parameter int                BE_TIMEOUT = 8000000,
  parameter logic [ADDR_W-1:0] IDLE_ADDR  = IDLE_ADDR_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  iceblips_bus_master_if.slave  cmd_if,
  output logic                  phi2,
  output logic                  web,
  output logic [ADDR_W-1:0]     address,
  inout  wire  [DATA_W-1:0]     data,
  input  logic                  be,
  output logic                  busy
);

  localparam int                STALL_W   = $clog2(BE_TIMEOUT + 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(BE_TIMEOUT);

  logic rise, fall;

  iceblips_phi2_gen #(.PHI2_DIV(PHI2_DIV)) u_phi2_gen (
    .clk    (clk),
    .rst    (reset),
    .phi2_o (phi2),
    .rise_o (rise),
    .fall_o (fall)
  );

  logic be_meta_q, be_sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      be_meta_q <= 1'b0;
      be_sync_q <= 1'b0;
    end else begin
      be_meta_q <= be;
      be_sync_q <= be_meta_q;
    end
  end

  state_e            state_q, state_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              web_q, web_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic              drive_q, drive_d;
  logic              hold_q, hold_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_error_q, rsp_error_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    web_d       = web_q;
    address_d   = address_q;
    drive_d     = drive_q;
    hold_d      = 1'b0;
    stall_d     = stall_q;
    rsp_valid_d = 1'b0;
    rsp_error_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;

    // Write data is held one clk past the closing fall edge, then released.
    if (hold_q) drive_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_if.cmd_valid) begin
          write_d = cmd_if.cmd_write;
          addr_d  = cmd_if.cmd_addr;
          wdata_d = cmd_if.cmd_wdata;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (fall) begin
          if (be_sync_q) begin
            address_d = addr_q;
            web_d     = ~write_q;
            state_d   = CYCLE;
          end else if (stall_q != STALL_MAX) begin
            stall_d = stall_q + 1'b1;
            if (stall_d == STALL_MAX) begin
              rsp_valid_d = 1'b1;
              rsp_error_d = 1'b1;
              rsp_rdata_d = '0;
              stall_d     = '0;
              state_d     = IDLE;
            end
          end
        end
      end
      CYCLE: begin
        if (rise && write_q) drive_d = 1'b1;
        if (fall) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = write_q ? '0 : data;
          address_d   = IDLE_ADDR;
          web_d       = 1'b1;
          stall_d     = '0;
          hold_d      = write_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      web_q       <= 1'b1;
      address_q   <= IDLE_ADDR;
      drive_q     <= 1'b0;
      hold_q      <= 1'b0;
      stall_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      web_q       <= web_d;
      address_q   <= address_d;
      drive_q     <= drive_d;
      hold_q      <= hold_d;
      stall_q     <= stall_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign data             = drive_q ? wdata_q : 'z;
  assign web              = web_q;
  assign address          = address_q;
  assign busy             = (state_q != IDLE);
  assign cmd_if.cmd_ready = (state_q == IDLE);
  assign cmd_if.rsp_valid = rsp_valid_q;
  assign cmd_if.rsp_error = rsp_error_q;
  assign cmd_if.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_iceblips_bus_master.sv
// Bench for the iceblips bus initiator against a bus-memory responder model with a response scoreboard.
module tb_iceblips_bus_master;
  import iceblips_bus_pkg::*;

  typedef struct packed {
    logic       err;
    logic [3:0] rdata;
  } rsp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       be = 1'b1;
  logic       phi2, web, busy;
  logic [3:0] address;
  wire  [3:0] data;
  logic       probe_en = 1'b0;

  int n_cmp = 0;
  int n_mis = 0;
  int rsp_seen = 0;

  rsp_t       sb[$];
  logic [3:0] falls[$];
  logic       phi2_prev = 1'b0;
  logic [3:0] mem [16];

  iceblips_bus_master_if cmd_if ();

  iceblips_bus_master #(
    .PHI2_DIV   (2),
    .BE_TIMEOUT (5),
    .IDLE_ADDR  (4'hf)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .cmd_if  (cmd_if),
    .phi2    (phi2),
    .web     (web),
    .address (address),
    .data    (data),
    .be      (be),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Responder: drives read data while phi2 is high, captures writes on high-half clk edges.
  assign data = (phi2 && web) ? mem[address] : 'z;
  // Probe driver: a stray master drive would corrupt this known pattern.
  assign data = probe_en ? 4'ha : 'z;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= 4'(i);
      mem[2] <= 4'ha;
    end else if (phi2 && !web) begin
      mem[address] <= data;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmd_if.rsp_valid) begin
      rsp_seen <= rsp_seen + 1;
      if (sb.size() == 0) begin
        check("rsp_unexpected", 1, 0);
      end else begin
        check("rsp_rdata", cmd_if.rsp_rdata, sb[0].rdata);
        check("rsp_error", cmd_if.rsp_error, sb[0].err);
        void'(sb.pop_front());
      end
    end
    if (!phi2 && phi2_prev) falls.push_back(address);
    phi2_prev <= phi2;
  end

  task automatic issue(input logic wr, input logic [3:0] a, input logic [3:0] wd,
                       input logic err, input logic [3:0] rd);
    int n = 0;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_write = wr;
    cmd_if.cmd_addr  = a;
    cmd_if.cmd_wdata = wd;
    while (!cmd_if.cmd_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", cmd_if.cmd_ready, 1);
    sb.push_back(rsp_t'{err: err, rdata: rd});
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(tag, sb.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, nfall, viol, i2, i8, seen0;
    logic prev;

    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_write = 1'b0;
    cmd_if.cmd_addr  = '0;
    cmd_if.cmd_wdata = '0;

    repeat (3) @(negedge clk);
    probe_en = 1'b1;
    #1;
    check("rst_phi2", phi2, 0);
    check("rst_web", web, 1);
    check("rst_addr", address, 4'hf);
    check("rst_ready", cmd_if.cmd_ready, 1);
    check("rst_rsp_valid", cmd_if.rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_data_z", data, 4'ha);
    probe_en = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Write 5 to address 8
    issue(1'b1, 4'h8, 4'h5, 1'b0, 4'h0);
    cmd_if.cmd_valid = 1'b0;
    check("wr_busy", busy, 1);
    n = 0;
    while (web !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    check("wr_addr", address, 4'h8);
    n = 0;
    while (!(phi2 && !web) && n < 100) begin @(negedge clk); n++; end
    check("wr_data_high", data, 4'h5);
    n = 0;
    while (!cmd_if.rsp_valid && n < 100) begin @(negedge clk); n++; end
    check("wr_hold_data", data, 4'h5);
    check("wr_end_web", web, 1);
    check("wr_end_addr", address, 4'hf);
    @(negedge clk);
    probe_en = 1'b1;
    #1;
    check("wr_release", data, 4'ha);
    probe_en = 1'b0;
    drain("wr_drain");
    check("wr_mem", mem[8], 4'h5);

    // Reads
    issue(1'b0, 4'h2, 4'h0, 1'b0, 4'ha);
    cmd_if.cmd_valid = 1'b0;
    drain("rd2_drain");
    issue(1'b0, 4'h8, 4'h0, 1'b0, 4'h5);
    cmd_if.cmd_valid = 1'b0;
    drain("rd8_drain");

    // be held low for 3 periods after accept
    be = 1'b0;
    repeat (4) @(negedge clk);
    issue(1'b0, 4'h8, 4'h0, 1'b0, 4'h5);
    cmd_if.cmd_valid = 1'b0;
    prev = phi2; nfall = 0; viol = 0; n = 0;
    while (nfall < 3 && n < 100) begin
      @(negedge clk);
      n++;
      if (web !== 1'b1 || address !== 4'hf) viol++;
      if (!phi2 && prev) nfall++;
      prev = phi2;
    end
    check("stall_falls_seen", nfall, 3);
    check("stall_no_cycle", viol, 0);
    be = 1'b1;
    nfall = 0; n = 0;
    while (!cmd_if.rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
      if (!phi2 && prev) nfall++;
      prev = phi2;
    end
    check("stall_resume_falls", nfall, 2);
    drain("stall_drain");

    // be held low until timeout
    be = 1'b0;
    repeat (4) @(negedge clk);
    issue(1'b0, 4'h4, 4'h0, 1'b1, 4'h0);
    cmd_if.cmd_valid = 1'b0;
    prev = phi2; nfall = 0; viol = 0; n = 0;
    while (!cmd_if.rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
      if (web !== 1'b1 || address !== 4'hf) viol++;
      if (!phi2 && prev) nfall++;
      prev = phi2;
    end
    check("to_rsp_seen", cmd_if.rsp_valid, 1);
    check("to_falls", nfall, 5);
    check("to_no_cycle", viol, 0);
    drain("to_drain");
    be = 1'b1;
    repeat (4) @(negedge clk);

    // Back-to-back reads with cmd_valid held
    falls.delete();
    issue(1'b0, 4'h2, 4'h0, 1'b0, 4'ha);
    issue(1'b0, 4'h8, 4'h0, 1'b0, 4'h5);
    cmd_if.cmd_valid = 1'b0;
    drain("b2b_drain");
    i2 = -1; i8 = -1;
    foreach (falls[i]) begin
      if (falls[i] == 4'h2 && i2 < 0) i2 = i;
      if (falls[i] == 4'h8 && i8 < 0) i8 = i;
    end
    check("b2b_gap", i8 - i2, 2);
    check("b2b_idle_addr", (i2 >= 0 && i2 + 1 < falls.size()) ? falls[i2 + 1] : 4'h0, 4'hf);

    // Reset during the high half of a write
    issue(1'b1, 4'h3, 4'h6, 1'b0, 4'h0);
    cmd_if.cmd_valid = 1'b0;
    n = 0;
    while (!(phi2 && !web) && n < 100) begin @(negedge clk); n++; end
    check("rr_high_seen", phi2 && !web, 1);
    reset = 1'b1;
    probe_en = 1'b1;
    #1;
    sb.delete();
    seen0 = rsp_seen;
    check("rr_phi2", phi2, 0);
    check("rr_web", web, 1);
    check("rr_addr", address, 4'hf);
    check("rr_data_z", data, 4'ha);
    check("rr_busy", busy, 0);
    repeat (2) @(negedge clk);
    probe_en = 1'b0;
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("rr_no_rsp", rsp_seen, seen0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
